// File: rtl/mult_pkg.sv
// Shared types and helpers for the iterative shift-add multiplier.
package mult_pkg;

  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,
    OP_MULH   = 2'b01,
    OP_MULHSU = 2'b10,
    OP_MULHU  = 2'b11
  } mult_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } mult_state_e;

  function automatic logic op_signed_a(mult_op_e op);
    return (op == OP_MULH) || (op == OP_MULHSU);
  endfunction

  function automatic logic op_signed_b(mult_op_e op);
    return (op == OP_MULH);
  endfunction

endpackage

// File: rtl/mult_iter_if.sv
// Request/response and flush signals of mult_iter, seen from the multiplier (slave).
interface mult_iter_if #(
  parameter int XLEN = 32
) ();
  logic            flush_i;
  logic            valid_i;
  logic            ready_o;
  logic [1:0]      op_i;
  logic [XLEN-1:0] a_i;
  logic [XLEN-1:0] b_i;
  logic            valid_o;
  logic            ready_i;
  logic [XLEN-1:0] result_o;

  modport slave (
    input  flush_i, valid_i, op_i, a_i, b_i, ready_i,
    output ready_o, valid_o, result_o
  );

  modport master (
    output flush_i, valid_i, op_i, a_i, b_i, ready_i,
    input  ready_o, valid_o, result_o
  );
endinterface

// File: rtl/mult_step.sv
// One BUSY step: adds BITS_PER_CYCLE shifted partial products into the accumulator.
module mult_step #(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic [2*XLEN-1:0]         acc_i,
  input  logic [2*XLEN-1:0]         mcand_i,
  input  logic [BITS_PER_CYCLE-1:0] bits_i,
  output logic [2*XLEN-1:0]         acc_o
);

  always_comb begin
    acc_o = acc_i;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (bits_i[i]) acc_o = acc_o + (mcand_i << i);
    end
  end

endmodule

// File: rtl/mult_iter.sv
// Iterative RV-M multiplier (MUL/MULH/MULHSU/MULHU), BITS_PER_CYCLE bits per clock.
// Define MULT_ITER_EARLY_EXIT_EN to finish as soon as the remaining multiplier bits are zero.
module mult_iter
  import mult_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  mult_iter_if.slave bus
);

  localparam int STEPS = XLEN / BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(STEPS) + 1;
  localparam int PW    = 2 * XLEN;

  mult_state_e     state_q, state_d;
  logic            ready_q, ready_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [PW-1:0]   mcand_q, mcand_d;
  logic [XLEN-1:0] mplier_q, mplier_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            neg_q, neg_d;
  mult_op_e        op_q, op_d;

  logic [PW-1:0]   acc_step;
  logic [PW-1:0]   acc_fin;
  logic            last;
  logic            sa, sb;
  mult_op_e        op_in;

  mult_step #(
    .XLEN           (XLEN),
    .BITS_PER_CYCLE (BITS_PER_CYCLE)
  ) u_step (
    .acc_i   (acc_q),
    .mcand_i (mcand_q),
    .bits_i  (mplier_q[BITS_PER_CYCLE-1:0]),
    .acc_o   (acc_step)
  );

  always_comb begin
    state_d  = state_q;
    ready_d  = ready_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    op_d     = op_q;

    op_in   = mult_op_e'(bus.op_i);
    sa      = op_signed_a(op_in) && bus.a_i[XLEN-1];
    sb      = op_signed_b(op_in) && bus.b_i[XLEN-1];
    acc_fin = neg_q ? -acc_step : acc_step;
`ifdef MULT_ITER_EARLY_EXIT_EN
    last = (cnt_q == CNT_W'(STEPS - 1)) || ((mplier_q >> BITS_PER_CYCLE) == '0);
`else
    last = (cnt_q == CNT_W'(STEPS - 1));
`endif

    case (state_q)
      ST_IDLE: begin
        ready_d = 1'b1;
        if (bus.valid_i && ready_q) begin
          // The most negative value negates to itself, which is its correct unsigned magnitude.
          mcand_d  = {{XLEN{1'b0}}, (sa ? -bus.a_i : bus.a_i)};
          mplier_d = sb ? -bus.b_i : bus.b_i;
          neg_d    = sa ^ sb;
          op_d     = op_in;
          acc_d    = '0;
          cnt_d    = '0;
          ready_d  = 1'b0;
          state_d  = ST_BUSY;
        end
      end
      ST_BUSY: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << BITS_PER_CYCLE;
        mplier_d = mplier_q >> BITS_PER_CYCLE;
        cnt_d    = cnt_q + CNT_W'(1);
        if (last) begin
          result_d = (op_q == OP_MUL) ? acc_fin[XLEN-1:0] : acc_fin[PW-1:XLEN];
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.ready_i) begin
          state_d = ST_IDLE;
          ready_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end
    endcase

    if (bus.flush_i) begin
      state_d = ST_IDLE;
      ready_d = 1'b1;
      acc_d   = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      ready_q  <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      op_q     <= OP_MUL;
    end else begin
      state_q  <= state_d;
      ready_q  <= ready_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      op_q     <= op_d;
    end
  end

  assign bus.ready_o  = ready_q;
  assign bus.valid_o  = (state_q == ST_DONE);
  assign bus.result_o = result_q;

endmodule
